serial_slice_adder: RTL and testbench



---
 rtl/serial_slice_adder_if.sv | 34 +++
 rtl/serial_slice_adder.sv | 168 ++++++++++++++++
 tb/tb_serial_slice_adder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_slice_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_slice_adder_if
// Description : Request/response bundle between a multi-cycle controller and
//               serial_slice_adder. The controller drives the request side
//               (master); the adder drives the result side (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_slice_adder_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, ovf, zero
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, ovf, zero
    );
endinterface
`default_nettype wire

// File: rtl/serial_slice_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_slice_adder
// Description : Multi-cycle adder. Adds two WIDTH-bit operands SLICE bits per
//               clock, carrying between slices through a carry register, with
//               a start/busy/done handshake.
//               Optional macro SERIAL_ADD_SUB_EN: when defined, sub=1 at
//               accept turns the operation into a - b (effective B = ~b,
//               effective carry-in = ~cin). When undefined, sub is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_slice_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_slice_adder_if.slave  bus
);

    localparam int unsigned c_N     = WIDTH / SLICE;
    localparam int unsigned c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam int unsigned c_POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(c_N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_accept;
    logic                 w_last;

    // Operands are shifted right each RUN cycle so the active slice always
    // sits at the bottom; the MSBs are captured separately for overflow.
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_a_msb;
    logic                 r_b_msb;
    logic                 r_carry;
    logic [c_IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]     r_sum;
    logic                 r_cout;
    logic                 r_ovf;
    logic                 r_zero;

    logic [WIDTH-1:0]     w_b_eff;
    logic                 w_cin_eff;
    logic [SLICE:0]       w_slice_res;
    logic [c_POS_W-1:0]   w_lsb;
    logic [WIDTH-1:0]     w_sum_next;
    logic                 w_ovf_next;

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction is a + ~b + ~cin; cin=1 then acts as a borrow-in.
    assign w_b_eff   = bus.sub ? ~bus.b   : bus.b;
    assign w_cin_eff = bus.sub ? ~bus.cin : bus.cin;
`else
    logic w_unused_sub;
    assign w_unused_sub = bus.sub;
    assign w_b_eff      = bus.b;
    assign w_cin_eff    = bus.cin;
`endif

    // State register; reset aborts any operation without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; start is only honoured in IDLE and DONE.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_idx == c_IDX_LAST) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // One slice of addition plus the merged result it produces.
    always_comb begin
        w_slice_res = {1'b0, r_a[SLICE-1:0]} + {1'b0, r_b[SLICE-1:0]}
                    + (SLICE+1)'(r_carry);
        w_lsb       = c_POS_W'(32'(r_idx) * SLICE);
        w_sum_next  = r_sum;
        w_sum_next[w_lsb +: SLICE] = w_slice_res[SLICE-1:0];
        w_ovf_next  = (r_a_msb == r_b_msb) && (w_sum_next[WIDTH-1] != r_a_msb);
    end

    // Datapath: latch on accept, process one slice per RUN cycle, and
    // publish the flags on the final slice so they are valid with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b1;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= w_b_eff;
            r_a_msb <= bus.a[WIDTH-1];
            r_b_msb <= w_b_eff[WIDTH-1];
            r_carry <= w_cin_eff;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> SLICE;
            r_b     <= r_b >> SLICE;
            r_carry <= w_slice_res[SLICE];
            r_sum   <= w_sum_next;
            if (w_last) begin
                r_idx  <= '0;
                r_cout <= w_slice_res[SLICE];
                r_ovf  <= w_ovf_next;
                r_zero <= (w_sum_next == '0);
            end else begin
                r_idx  <= r_idx + c_IDX_W'(1);
            end
        end
    end

    assign bus.busy = (r_state == S_RUN);
    assign bus.done = (r_state == S_DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;
    assign bus.zero = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_serial_slice_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_slice_adder
// Description : Self-checking bench for serial_slice_adder (WIDTH=32,
//               SLICE=8). Expected values follow SERIAL_ADD_SUB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_slice_adder;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    serial_slice_adder_if #(.WIDTH(32)) bus_if ();

    serial_slice_adder #(
        .WIDTH (32),
        .SLICE (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Called at #1 after an accept edge: checks the accept-time clearing,
    // then waits (bounded) for done, counting busy cycles.
    task automatic finish_op(output int cycles, output int busy_cnt);
        cycles   = 0;
        busy_cnt = 0;
        @(negedge clk);
        cycles++;
        if (bus_if.busy) busy_cnt++;
        check("accept_sum_clear", bus_if.sum, 32'h0);
        check("accept_zero_clear", {31'b0, bus_if.zero}, 32'h0);
        while (!bus_if.done && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (bus_if.busy) busy_cnt++;
        end
    endtask

    // Drive one operation, then scramble the inputs right after accept.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input logic sub, output int cycles, output int busy_cnt);
        @(negedge clk);
        bus_if.a     = a;
        bus_if.b     = b;
        bus_if.cin   = cin;
        bus_if.sub   = sub;
        bus_if.start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        bus_if.a     = $urandom;
        bus_if.b     = $urandom;
        bus_if.cin   = ~cin;
        bus_if.sub   = ~sub;
        finish_op(cycles, busy_cnt);
    endtask

    initial begin
        vec_t vecs[11];
        int   cyc;
        int   bcnt;
        int   seen_done;

        n_cmp = 0;
        n_err = 0;

        vecs[0]  = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
`ifdef SERIAL_ADD_SUB_EN
        vecs[3]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0};
`else
        vecs[3]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'h0000000C, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h0000000C, 1'b0, 1'b0, 1'b0};
`endif
        vecs[5]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 32'h01000100, 1'b0, 1'b0, 1'b0};

        // Reset state
        rst_n        = 1'b0;
        bus_if.start = 1'b0;
        bus_if.a     = '0;
        bus_if.b     = '0;
        bus_if.cin   = 1'b0;
        bus_if.sub   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, bus_if.busy}, 32'h0);
        check("rst_done", {31'b0, bus_if.done}, 32'h0);
        check("rst_sum",  bus_if.sum, 32'h0);
        check("rst_cout", {31'b0, bus_if.cout}, 32'h0);
        check("rst_ovf",  {31'b0, bus_if.ovf}, 32'h0);
        check("rst_zero", {31'b0, bus_if.zero}, 32'h1);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, cyc, bcnt);
            check($sformatf("v%0d_latency", i), cyc, 32'd5);
            check($sformatf("v%0d_busy_cycles", i), bcnt, 32'd4);
            check($sformatf("v%0d_sum", i), bus_if.sum, vecs[i].sum);
            check($sformatf("v%0d_cout", i), {31'b0, bus_if.cout}, {31'b0, vecs[i].cout});
            check($sformatf("v%0d_ovf", i), {31'b0, bus_if.ovf}, {31'b0, vecs[i].ovf});
            check($sformatf("v%0d_zero", i), {31'b0, bus_if.zero}, {31'b0, vecs[i].zero});
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), {31'b0, bus_if.done}, 32'h0);
            check($sformatf("v%0d_sum_held", i), bus_if.sum, vecs[i].sum);
        end

        // Back-to-back: start held in DONE, second op accepted with no IDLE
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, cyc, bcnt);
        check("b2b_first_sum", bus_if.sum, 32'h80000000);
        check("b2b_first_ovf", {31'b0, bus_if.ovf}, 32'h1);
        bus_if.a     = 32'h3;
        bus_if.b     = 32'h4;
        bus_if.cin   = 1'b0;
        bus_if.sub   = 1'b0;
        bus_if.start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        finish_op(cyc, bcnt);
        check("b2b_latency", cyc, 32'd5);
        check("b2b_busy_cycles", bcnt, 32'd4);
        check("b2b_sum", bus_if.sum, 32'h7);
        check("b2b_ovf", {31'b0, bus_if.ovf}, 32'h0);

        // Asynchronous reset in RUN cycle 2: no done afterwards
        @(negedge clk);
        bus_if.a     = 32'h10;
        bus_if.b     = 32'h20;
        bus_if.cin   = 1'b0;
        bus_if.start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, bus_if.busy}, 32'h0);
        check("abort_done", {31'b0, bus_if.done}, 32'h0);
        check("abort_sum",  bus_if.sum, 32'h0);
        check("abort_zero", {31'b0, bus_if.zero}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus_if.done) seen_done++;
        end
        check("abort_no_done", seen_done, 32'd0);
        run_op(32'h10, 32'h20, 1'b0, 1'b0, cyc, bcnt);
        check("after_abort_latency", cyc, 32'd5);
        check("after_abort_sum", bus_if.sum, 32'h30);

        // start and operand changes during RUN are ignored
        @(negedge clk);
        bus_if.a     = 32'h11111111;
        bus_if.b     = 32'h22222222;
        bus_if.cin   = 1'b0;
        bus_if.start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.a     = 32'hFFFFFFFF;
        bus_if.b     = 32'hFFFFFFFF;
        bus_if.cin   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        cyc = 0;
        while (!bus_if.done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("ignore_latency", cyc, 32'd2);
        check("ignore_sum", bus_if.sum, 32'h33333333);
        check("ignore_cout", {31'b0, bus_if.cout}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
